// File: rtl/adsr_envelope_gen.sv
// ADSR envelope generator: synchronised, debounced gate driving a
// four-stage volume envelope with live-programmable rates and sustain.
module adsr_envelope_gen #(
   parameter int VOLUME_BITS    = 8,
   parameter int RATE_BITS      = 16,
   parameter int DEBOUNCE_COUNT = 500
) (
   input  logic                   mclk,
   input  logic                   rst_n,
   input  logic                   gate_raw,
   input  logic [RATE_BITS-1:0]   attack_rate,
   input  logic [RATE_BITS-1:0]   decay_rate,
   input  logic [RATE_BITS-1:0]   release_rate,
   input  logic [VOLUME_BITS-1:0] sustain_level,
   output logic [VOLUME_BITS-1:0] volume,
   output logic [2:0]             stage,
   output logic                   active
);

   localparam logic [VOLUME_BITS-1:0] VMAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } stage_e;

   logic                   sync1_q, sync2_q;
   logic                   gate_db;
   logic                   gate_prev_q;
   logic                   rise, fall;
   stage_e                 stage_q, stage_d;
   logic [VOLUME_BITS-1:0] vol_q, vol_d;
   logic [RATE_BITS-1:0]   cnt_q, cnt_d;
   logic [RATE_BITS-1:0]   rate;
   logic                   step;
   logic                   active_q, active_d;

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= gate_raw;
         sync2_q <= sync1_q;
      end
   end

   if (DEBOUNCE_COUNT == 0) begin : g_bypass
      assign gate_db = sync2_q;
   end else begin : g_db
      localparam int DB_W = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
      localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_COUNT - 1);

      logic            db_q, db_d;
      logic [DB_W-1:0] db_cnt_q, db_cnt_d;

      // The sample that completes DEBOUNCE_COUNT disagreeing cycles flips
      // gate_db on the same edge and restarts the count.
      always_comb begin
         db_d     = db_q;
         db_cnt_d = '0;
         if (sync2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
               db_d = ~db_q;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
      end

      always_ff @(posedge mclk or negedge rst_n) begin
         if (!rst_n) begin
            db_q     <= 1'b0;
            db_cnt_q <= '0;
         end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
         end
      end

      assign gate_db = db_q;
   end

   assign rise = gate_db & ~gate_prev_q;
   assign fall = ~gate_db & gate_prev_q;

   always_comb begin
      rate = attack_rate;
      if (stage_q == ST_DECAY) begin
         rate = decay_rate;
      end else if (stage_q == ST_RELEASE) begin
         rate = release_rate;
      end
      step = (cnt_q >= rate);
   end

   // Gate edges take priority over steps and level-reached transitions.
   always_comb begin
      stage_d = stage_q;
      vol_d   = vol_q;
      cnt_d   = '0;
      unique case (stage_q)
         ST_IDLE: begin
            vol_d = '0;
            if (rise) begin
               stage_d = ST_ATTACK;
            end
         end
         ST_ATTACK: begin
            if (fall) begin
               stage_d = ST_RELEASE;
            end else if (vol_q == VMAX) begin
               stage_d = ST_DECAY;
            end else if (step) begin
               vol_d = vol_q + VOLUME_BITS'(1);
            end else begin
               cnt_d = cnt_q + RATE_BITS'(1);
            end
         end
         ST_DECAY: begin
            if (fall) begin
               stage_d = ST_RELEASE;
            end else if (vol_q <= sustain_level) begin
               stage_d = ST_SUSTAIN;
               vol_d   = sustain_level;
            end else if (step) begin
               vol_d = vol_q - VOLUME_BITS'(1);
            end else begin
               cnt_d = cnt_q + RATE_BITS'(1);
            end
         end
         ST_SUSTAIN: begin
            if (fall) begin
               stage_d = ST_RELEASE;
            end else begin
               vol_d = sustain_level;
            end
         end
         ST_RELEASE: begin
            if (rise) begin
               stage_d = ST_ATTACK;
            end else if (vol_q == '0) begin
               stage_d = ST_IDLE;
            end else if (step) begin
               vol_d = vol_q - VOLUME_BITS'(1);
            end else begin
               cnt_d = cnt_q + RATE_BITS'(1);
            end
         end
         default: begin
            stage_d = ST_IDLE;
            vol_d   = '0;
         end
      endcase
      active_d = (stage_d != ST_IDLE);
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         gate_prev_q <= 1'b0;
         stage_q     <= ST_IDLE;
         vol_q       <= '0;
         cnt_q       <= '0;
         active_q    <= 1'b0;
      end else begin
         gate_prev_q <= gate_db;
         stage_q     <= stage_d;
         vol_q       <= vol_d;
         cnt_q       <= cnt_d;
         active_q    <= active_d;
      end
   end

   assign volume = vol_q;
   assign stage  = stage_q;
   assign active = active_q;

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// Scoreboard bench for adsr_envelope_gen: directed ADSR scenarios then
// randomised gate/rate/sustain traffic against a cycle reference model.
module tb_adsr_envelope_gen;

   localparam int VB   = 4;
   localparam int RB   = 8;
   localparam int DB   = 4;
   localparam int VMAX = (1 << VB) - 1;

   localparam int P_IDLE = 0;
   localparam int P_ATT  = 1;
   localparam int P_DEC  = 2;
   localparam int P_SUS  = 3;
   localparam int P_REL  = 4;

   logic          mclk = 1'b0;
   logic          rst_n;
   logic          gate_raw;
   logic [RB-1:0] attack_rate;
   logic [RB-1:0] decay_rate;
   logic [RB-1:0] release_rate;
   logic [VB-1:0] sustain_level;
   logic [VB-1:0] volume;
   logic [2:0]    stage;
   logic          active;

   typedef struct {
      int vol;
      int stg;
      int act;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference state: synchroniser, debounce history, envelope phase.
   int ms1 = 0, ms2 = 0, mdb = 0, mprev = 0;
   int hist[$];
   int mph = P_IDLE, mlvl = 0, mwait = 0;

   adsr_envelope_gen #(
      .VOLUME_BITS   (VB),
      .RATE_BITS     (RB),
      .DEBOUNCE_COUNT(DB)
   ) dut (
      .mclk         (mclk),
      .rst_n        (rst_n),
      .gate_raw     (gate_raw),
      .attack_rate  (attack_rate),
      .decay_rate   (decay_rate),
      .release_rate (release_rate),
      .sustain_level(sustain_level),
      .volume       (volume),
      .stage        (stage),
      .active       (active)
   );

   always #5 mclk = ~mclk;

   function automatic void model_step();
      int rate, nph, nlvl;
      bit rise, fall, stepping, restart, alldiff;
      exp_t e;
      if (!rst_n) begin
         ms1 = 0; ms2 = 0; mdb = 0; mprev = 0;
         hist.delete();
         mph = P_IDLE; mlvl = 0; mwait = 0;
      end else begin
         rise = (mdb == 1) && (mprev == 0);
         fall = (mdb == 0) && (mprev == 1);
         if (mph == P_ATT) rate = int'(attack_rate);
         else if (mph == P_DEC) rate = int'(decay_rate);
         else rate = int'(release_rate);
         stepping = (mph == P_ATT || mph == P_DEC || mph == P_REL)
                    && (mwait >= rate);
         nph = mph; nlvl = mlvl; restart = 0;
         if (rise && (mph == P_IDLE || mph == P_REL)) begin
            nph = P_ATT; restart = 1;
         end else if (fall && (mph == P_ATT || mph == P_DEC || mph == P_SUS)) begin
            nph = P_REL; restart = 1;
         end else begin
            case (mph)
               P_IDLE: nlvl = 0;
               P_ATT: begin
                  if (mlvl == VMAX) begin nph = P_DEC; restart = 1; end
                  else if (stepping) nlvl = mlvl + 1;
               end
               P_DEC: begin
                  if (mlvl <= int'(sustain_level)) begin
                     nph = P_SUS; nlvl = int'(sustain_level); restart = 1;
                  end else if (stepping) nlvl = mlvl - 1;
               end
               P_SUS: nlvl = int'(sustain_level);
               default: begin
                  if (mlvl == 0) begin nph = P_IDLE; restart = 1; end
                  else if (stepping) nlvl = mlvl - 1;
               end
            endcase
         end
         if (restart || stepping || nph == P_IDLE || nph == P_SUS) mwait = 0;
         else mwait = mwait + 1;
         mph = nph; mlvl = nlvl;
         // gate_db flips once the last DB synchronised samples all disagree
         hist.push_back(ms2);
         if (hist.size() > DB) void'(hist.pop_front());
         mprev = mdb;
         if (hist.size() == DB) begin
            alldiff = 1;
            foreach (hist[i]) if (hist[i] == mdb) alldiff = 0;
            if (alldiff) mdb = 1 - mdb;
         end
         ms2 = ms1;
         ms1 = int'(gate_raw);
      end
      e.vol = mlvl;
      e.stg = mph;
      e.act = (mph != P_IDLE) ? 1 : 0;
      exp_q.push_back(e);
   endfunction

   task automatic tick();
      model_step();
      @(negedge mclk);
   endtask

   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, expv);
      end
   endtask

   always @(posedge mclk) begin : monitor
      exp_t e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (int'(volume) != e.vol || int'(stage) != e.stg || int'(active) != e.act) begin
            n_bad++;
            $display("FAIL scoreboard t=%0t: vol/stage/active got %0d/%0d/%0d want %0d/%0d/%0d",
                     $time, volume, stage, active, e.vol, e.stg, e.act);
         end
      end
   end

   initial begin
      int len, r;
      rst_n = 1'b0; gate_raw = 1'b1;
      attack_rate = 8'd1; decay_rate = 8'd0; release_rate = 8'd2;
      sustain_level = 4'd10;
      @(negedge mclk);
      tick(); tick();
      chk("reset_volume", int'(volume), 0);
      chk("reset_stage", int'(stage), 0);
      chk("reset_active", int'(active), 0);

      rst_n = 1'b1;
      repeat (6) tick();
      chk("edge6_still_idle", int'(stage), 0);
      tick();
      chk("edge7_attack", int'(stage), 1);
      chk("edge7_active", int'(active), 1);

      repeat (30) tick();
      chk("attack_peak_vol", int'(volume), 15);
      chk("attack_peak_stage", int'(stage), 1);
      tick();
      chk("decay_entry", int'(stage), 2);
      repeat (5) tick();
      chk("decay_end_vol", int'(volume), 10);
      tick();
      chk("sustain_stage", int'(stage), 3);
      chk("sustain_vol", int'(volume), 10);
      repeat (10) tick();
      gate_raw = 1'b0;
      repeat (7) tick();
      chk("release_entry_stage", int'(stage), 4);
      chk("release_entry_vol", int'(volume), 10);
      repeat (30) tick();
      chk("release_zero_vol", int'(volume), 0);
      chk("release_zero_stage", int'(stage), 4);
      tick();
      chk("back_idle", int'(stage), 0);
      chk("back_idle_active", int'(active), 0);

      repeat (5) tick();
      gate_raw = 1'b1;
      repeat (3) tick();
      gate_raw = 1'b0;
      repeat (20) tick();
      chk("glitch_stage", int'(stage), 0);
      chk("glitch_vol", int'(volume), 0);

      gate_raw = 1'b1;
      repeat (13) tick();
      gate_raw = 1'b0;
      repeat (7) tick();
      chk("early_rel_stage", int'(stage), 4);
      chk("early_rel_vol", int'(volume), 6);
      repeat (3) tick();
      gate_raw = 1'b1;
      repeat (7) tick();
      chk("legato_stage", int'(stage), 1);
      chk("legato_vol", int'(volume), 3);
      repeat (40) tick();
      gate_raw = 1'b0;
      repeat (45) tick();
      chk("legato_done_idle", int'(stage), 0);

      attack_rate = 8'd0; sustain_level = 4'd15;
      gate_raw = 1'b1;
      repeat (7) tick();
      chk("s15_attack", int'(stage), 1);
      repeat (15) tick();
      chk("s15_peak", int'(volume), 15);
      tick();
      chk("s15_decay_pass", int'(stage), 2);
      tick();
      chk("s15_sustain", int'(stage), 3);
      chk("s15_sustain_vol", int'(volume), 15);
      sustain_level = 4'd10;
      tick();
      chk("sus_track_10", int'(volume), 10);
      repeat (3) tick();
      sustain_level = 4'd4;
      tick();
      chk("sus_track_4", int'(volume), 4);
      gate_raw = 1'b0; release_rate = 8'd0;
      repeat (13) tick();
      chk("s5_idle", int'(stage), 0);

      attack_rate = 8'd100;
      gate_raw = 1'b1;
      repeat (37) tick();
      chk("slow_attack_vol", int'(volume), 0);
      chk("slow_attack_stage", int'(stage), 1);
      attack_rate = 8'd0;
      tick();
      chk("live_rate_step1", int'(volume), 1);
      tick();
      chk("live_rate_step2", int'(volume), 2);
      tick();
      chk("live_rate_step3", int'(volume), 3);
      gate_raw = 1'b0;
      repeat (20) tick();

      for (int s = 0; s < 60; s++) begin
         gate_raw = ~gate_raw;
         len = $urandom_range(1, 50);
         for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 99);
            if (r < 4) attack_rate = RB'($urandom_range(0, 6));
            else if (r < 8) decay_rate = RB'($urandom_range(0, 6));
            else if (r < 12) release_rate = RB'($urandom_range(0, 6));
            else if (r < 15) sustain_level = VB'($urandom_range(0, VMAX));
            else if (r == 15) begin
               rst_n = 1'b0;
               tick();
               rst_n = 1'b1;
            end
            tick();
         end
      end

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adsr_envelope_gen.md
Name: adsr_envelope_gen

Overview:
- Parametrised successor to the single-button attack/release volume envelope.
- Four-stage ADSR envelope generator with runtime-programmable attack, decay and release rates and sustain level. Includes synchronised, debounced gate input and legato retrigger.
- Drives the volume input of any tone source (triangle, player) in the synth voice path.
- Runs in the mclk domain.

Parameters:
VOLUME_BITS, 8, width of volume output and sustain_level; VMAX = 2^VOLUME_BITS-1
RATE_BITS, 16, width of each rate input (mclk cycles per volume step, minus 1)
DEBOUNCE_COUNT, 500, consecutive stable cycles before gate change accepted; 0 = bypass debounce (synchroniser kept)

Ports:
mclk  in  1  master clock (256x sample rate)
rst_n  in  1  asynchronous, active-low reset
gate_raw  in  1  raw, asynchronous key/button gate
attack_rate  in  RATE_BITS  attack step period minus 1
decay_rate  in  RATE_BITS  decay step period minus 1
release_rate  in  RATE_BITS  release step period minus 1
sustain_level  in  VOLUME_BITS  sustain volume
volume  out  VOLUME_BITS  envelope output, registered
stage  out  3  one-hot-free encoding: 0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
active  out  1  high whenever stage != IDLE

Behaviour:
- Reset (rst_n low, async): volume=0, stage=IDLE, active=0, sync flops=0, gate_db=0, debounce and step counters=0. Release of rst_n is synchronous to mclk.
- Gate path:
  - Two-flop synchroniser gives gate_sync.
  - Debounce counter increments while gate_sync != gate_db and clears when they are equal.
  - gate_db toggles when the count reaches DEBOUNCE_COUNT; the counter clears at the same time.
  - Latency: raw edge seen at mclk edge 0 gives gate_sync at edge 2, gate_db at edge 2+DEBOUNCE_COUNT, stage change at edge 3+DEBOUNCE_COUNT.
  - Glitches shorter than DEBOUNCE_COUNT cycles are ignored.
- Step counter:
  - Counts mclk cycles in ATTACK, DECAY and RELEASE.
  - A step fires when count >= the active rate; the counter then clears. Step period = rate+1 cycles; rate 0 steps every cycle.
  - The counter clears on every stage transition.
  - Rates are read live. Lowering a rate below the current count fires on the next cycle.
- IDLE: volume held at 0. gate_db rise -> ATTACK.
- ATTACK: +1 per step.
  - When volume reaches VMAX -> DECAY on the following cycle.
  - Saturates at VMAX; never wraps.
- DECAY: -1 per step while volume > sustain_level.
  - volume <= sustain_level -> SUSTAIN, with volume loaded with sustain_level. This includes sustain_level=VMAX, which gives a one-cycle DECAY pass.
- SUSTAIN: volume tracks sustain_level every cycle (live edits audible).
- gate_db fall in ATTACK/DECAY/SUSTAIN -> RELEASE, starting from the current volume with no jump.
- RELEASE: -1 per step.
  - Volume 0 -> IDLE on the following cycle; never underflows.
- gate_db rise in RELEASE -> ATTACK from the current volume (legato, no reset to 0).
- Priority: a gate edge outranks a same-cycle step or level-reached transition; the step is discarded.
- Reset asserted mid-envelope immediately forces the reset values above.
- active = (stage != IDLE), registered with stage.

Test Plan:
All scenarios use VOLUME_BITS=4, DEBOUNCE_COUNT=4 unless noted.
1. Reset: rst_n low with gate_raw=1 -> volume=0, stage=0, active=0. After release with gate held: stage=1 at edge 7.
2. Full ADSR, attack_rate=1, decay_rate=0, sustain_level=10, release_rate=2:
   - Volume ramps 0->15 in 30 cycles, then 15->10 in 5 cycles, then holds at stage=3.
   - Gate fall -> 10->0 in 30 cycles, then stage=0, active=0.
3. Glitch rejection: 3-cycle gate_raw pulse -> stage stays 0, volume stays 0.
4. Early release: gate falls at attack volume 6 -> RELEASE from 6 without a jump. Regate at volume 3 -> ATTACK resumes from 3.
5. Edge cases:
   - sustain_level=15 -> DECAY lasts one cycle, SUSTAIN at 15.
   - sustain_level changed 10->4 during SUSTAIN -> volume=4 on the next cycle.
6. Live rate change: attack_rate changed 100->0 mid-step -> a step fires on the next cycle, then every cycle after.
